// File: rtl/fifo_to_axi_pkg.sv
// Shared definitions for the SRAM FIFO read path: word field offsets,
// TUSER tag placement and packet state encoding.
package nf10_sram_fifo_pkg;

  localparam int TLAST_BIT     = 0;
  localparam int DATA_LSB      = 1;
  localparam int TAG_LSB       = 8 * 8 + 1;
  localparam int TUSER_TAG_LSB = 24;

  typedef enum logic [0:0] {
    ST_SOP = 1'b0,
    ST_MID = 1'b1
  } pkt_state_e;

  // Tag field offset for a non-default data width.
  function automatic int tag_lsb(input int tdata_bytes);
    return 8 * tdata_bytes + 1;
  endfunction

endpackage

// File: rtl/fifo_to_axi_if.sv
// AXI4-Stream bundle carrying reconstructed packets to the output-queue stage.
interface fifo_to_axi_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 128
);
  logic                     tvalid;
  logic                     tready;
  logic [8*TDATA_WIDTH-1:0] tdata;
  logic [TDATA_WIDTH-1:0]   tstrb;
  logic [TDATA_WIDTH-1:0]   tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/fifo_to_axi_out_buf.sv
// Two-entry registered skid FIFO; entry 0 is always the head presented downstream.
module fifo_out_buf #(
  parameter int W = 69
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic [1:0]   occupancy_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_s;

  assign pop_s       = pop_i & (cnt_q != 2'd0);
  assign full_o      = (cnt_q == 2'd2);
  assign occupancy_o = cnt_q;
  assign head_o      = ent0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  // Push lands behind whatever survives this cycle's pop, preserving order.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_data_i;
        else               ent1_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end else begin
          ent0_d = push_data_i;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

endmodule

// File: rtl/fifo_to_axi.sv
// Drains SRAM FIFO words into an AXI4-Stream master, restoring TLAST and the
// per-packet destination tag, and returns one credit per delivered beat.
module fifo_to_axi
  import nf10_sram_fifo_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 128,
  parameter int TAG_WIDTH   = 4,
  parameter int WORD_WIDTH  = 8 * TDATA_WIDTH + 1 + TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cal_done,
  input  logic                  fifo_rempty,
  output logic                  fifo_rinc,
  input  logic                  fifo_dout_valid,
  input  logic [WORD_WIDTH-1:0] fifo_dout,
  fifo_to_axi_if.master         m,
  output logic                  output_inc,
  output logic [31:0]           output_fifo_cnt
);

  localparam int DW   = 8 * TDATA_WIDTH;
  localparam int TAGL = tag_lsb(TDATA_WIDTH);

  logic                  inflight_q, inflight_d;
  pkt_state_e            state_q, state_d;
  logic [TAG_WIDTH-1:0]  sop_tag_q, sop_tag_d;
  logic                  output_inc_q;
  logic [31:0]           cnt_q;

  logic                  pop_s, push_s, buf_full_s;
  logic [1:0]            occ_s, occ_after_s;
  logic [TAG_WIDTH-1:0]  push_tag_s, w_tag_s, head_tag_s;
  logic [DW-1:0]         w_data_s;
  logic                  w_last_s;
  logic [WORD_WIDTH-1:0] push_word_s, head_s;

  assign w_last_s = fifo_dout[TLAST_BIT];
  assign w_data_s = fifo_dout[DW:DATA_LSB];
  assign w_tag_s  = fifo_dout[WORD_WIDTH-1:TAGL];

  assign pop_s       = m.tvalid & m.tready;
  assign occ_after_s = occ_s - {1'b0, pop_s};
  // Words without an outstanding read are stray and dropped.
  assign push_s      = fifo_dout_valid & inflight_q & (~buf_full_s | pop_s);
  assign push_word_s = {push_tag_s, w_data_s, w_last_s};

  always_comb begin
    fifo_rinc = 1'b0;
    if (!reset && cal_done && !fifo_rempty &&
        (({1'b0, occ_after_s} + {2'b00, inflight_q}) < 3'd2)) begin
      fifo_rinc = 1'b1;
    end else begin
      fifo_rinc = 1'b0;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (fifo_rinc)            inflight_d = 1'b1;
    else if (fifo_dout_valid) inflight_d = 1'b0;
    else                      inflight_d = inflight_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SOP;
      sop_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      sop_tag_q <= sop_tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SOP: if (push_s && !w_last_s) state_d = ST_MID;
              else                     state_d = ST_SOP;
      ST_MID: if (push_s && w_last_s)  state_d = ST_SOP;
              else                     state_d = ST_MID;
      default: state_d = ST_SOP;
    endcase
  end

  // Continuation beats inherit the tag captured on the packet's first word.
  always_comb begin
    push_tag_s = sop_tag_q;
    sop_tag_d  = sop_tag_q;
    if (state_q == ST_SOP) begin
      push_tag_s = w_tag_s;
      if (push_s) sop_tag_d = w_tag_s;
      else        sop_tag_d = sop_tag_q;
    end else begin
      push_tag_s = sop_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q   <= 1'b0;
      output_inc_q <= 1'b0;
      cnt_q        <= 32'd0;
    end else begin
      inflight_q   <= inflight_d;
      output_inc_q <= pop_s;
      cnt_q        <= cnt_q + {31'd0, pop_s};
    end
  end

  fifo_out_buf #(
    .W(WORD_WIDTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (push_word_s),
    .pop_i       (pop_s),
    .full_o      (buf_full_s),
    .occupancy_o (occ_s),
    .head_o      (head_s)
  );

  assign head_tag_s      = head_s[WORD_WIDTH-1:TAGL];
  assign m.tvalid        = (occ_s != 2'd0);
  assign m.tdata         = head_s[DW:DATA_LSB];
  assign m.tlast         = head_s[TLAST_BIT];
  assign m.tstrb         = {TDATA_WIDTH{1'b1}};
  assign m.tkeep         = {TDATA_WIDTH{1'b1}};
  assign m.tuser         = {{(TUSER_WIDTH - TUSER_TAG_LSB - TAG_WIDTH){1'b0}},
                            head_tag_s, {TUSER_TAG_LSB{1'b0}}};
  assign output_inc      = output_inc_q;
  assign output_fifo_cnt = cnt_q;

endmodule
